// File: rtl/d_lock_pkg.sv
// Shared definitions for the digital lock controller and the timer block.
package d_lock_pkg;

  localparam int CODE_LEN_DEF = 4;
  localparam int DIGIT_W_DEF  = 4;
  localparam int MAX_ERR_DEF  = 3;

  // The timer block sizes its error input with this width too.
  localparam int ERR_W = 3;
  // Wide enough to hold CODE_LEN (up to 8) as a count.
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_OPEN    = 3'd0,
    S_SET     = 3'd1,
    S_LOCKED  = 3'd2,
    S_ENTRY   = 3'd3,
    S_CHECK   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  // Error count plus one, saturating at the limit.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] e,
                                               input logic [ERR_W-1:0] lim);
    return (e >= lim) ? lim : e + 1'b1;
  endfunction

endpackage

// File: rtl/d_lock_code_buf.sv
// Digit capture buffer: writes digits MSB-first at an incrementing index,
// reports full once CODE_LEN digits are held, and clears on request.
module d_lock_code_buf
  import d_lock_pkg::*;
#(
  parameter int CODE_LEN = CODE_LEN_DEF,
  parameter int DIGIT_W  = DIGIT_W_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_wr,
  input  logic [DIGIT_W-1:0]           i_digit,
  output logic [CODE_LEN*DIGIT_W-1:0]  o_data,
  output logic [IDX_W-1:0]             o_idx,
  output logic                         o_full
);

  logic [CODE_LEN*DIGIT_W-1:0] r_data;
  logic [IDX_W-1:0]            r_idx;
  logic                        w_full;

  assign w_full = (r_idx == IDX_W'(CODE_LEN));

  // Capture a digit at the current index; clear wins over a write.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_data <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_data <= '0;
      r_idx  <= '0;
    end else if (i_wr && !w_full) begin
      r_data[(CODE_LEN-1-int'(r_idx))*DIGIT_W +: DIGIT_W] <= i_digit;
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_idx  = r_idx;
  assign o_full = w_full;

endmodule

// File: rtl/d_lock_ctrl.sv
// Lock-side controller: collects keypad digits, holds and compares the code,
// counts failed attempts and drives the timer/LED block's control inputs.
// Handshake: the btn_* inputs are single-cycle strobes, consumed in the cycle
// they are high; enb_cnt/disable_cnt are single-cycle strobes to the timer.
module d_lock_ctrl
  import d_lock_pkg::*;
#(
  parameter int CODE_LEN = CODE_LEN_DEF,
  parameter int DIGIT_W  = DIGIT_W_DEF,
  parameter int MAX_ERR  = MAX_ERR_DEF,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] sw_digit,
  input  logic               btn_enter,
  input  logic               btn_set,
  input  logic               btn_lock,
  input  logic               enb_set,
  input  logic               enb_inp,
  input  logic               timer_reset,
  output logic               enb_lock,
  output logic               enb_cnt,
  output logic               disable_cnt,
  output logic               ignore,
  output logic               gen_stop,
  output logic [ERR_W-1:0]   error_counter,
  output logic [2:0]         digit_idx,
  output state_e             o_state_dbg
);

  localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(MAX_ERR);

  state_e                      r_state, w_state_nxt, w_fail_st;
  logic [CODE_LEN*DIGIT_W-1:0] r_code;
  logic [ERR_W-1:0]            r_err, w_err_nxt, w_err_inc;
  logic                        r_enb_lock, r_enb_cnt, r_dis, r_ignore, r_gen_stop;
  logic                        w_enb_cnt_nxt, w_dis_nxt, w_code_load, w_match;
  logic                        w_ent_clr, w_ent_wr, w_ent_full;
  logic                        w_set_clr, w_set_wr, w_set_full;
  logic [CODE_LEN*DIGIT_W-1:0] w_ent_data, w_set_data;
  logic [IDX_W-1:0]            w_ent_idx, w_set_idx;

  d_lock_code_buf #(.CODE_LEN(CODE_LEN), .DIGIT_W(DIGIT_W)) u_entry_buf (
    .clk_in (clk_in),    .rst_n  (rst_n),
    .i_clear(w_ent_clr), .i_wr   (w_ent_wr),  .i_digit(sw_digit),
    .o_data (w_ent_data), .o_idx (w_ent_idx), .o_full (w_ent_full)
  );

  d_lock_code_buf #(.CODE_LEN(CODE_LEN), .DIGIT_W(DIGIT_W)) u_set_buf (
    .clk_in (clk_in),    .rst_n  (rst_n),
    .i_clear(w_set_clr), .i_wr   (w_set_wr),  .i_digit(sw_digit),
    .o_data (w_set_data), .o_idx (w_set_idx), .o_full (w_set_full)
  );

  assign w_match   = (w_ent_data == r_code);
  assign w_err_inc = err_inc(r_err, ERR_LIM);
  assign w_fail_st = (w_err_inc == ERR_LIM) ? S_LOCKOUT : S_LOCKED;

  // Next-state, buffer control and next output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_err_nxt     = r_err;
    w_enb_cnt_nxt = 1'b0;
    w_dis_nxt     = 1'b0;
    w_code_load   = 1'b0;
    w_ent_clr     = 1'b0;
    w_ent_wr      = 1'b0;
    w_set_clr     = 1'b0;
    w_set_wr      = 1'b0;
    case (r_state)
      S_OPEN: begin
        if (btn_lock)                w_state_nxt = S_LOCKED;
        else if (btn_set && enb_set) w_state_nxt = S_SET;
      end
      S_SET: begin
        if (w_set_full) begin
          w_code_load = 1'b1;
          w_set_clr   = 1'b1;
          w_state_nxt = S_OPEN;
        end else if (!enb_set) begin
          w_set_clr   = 1'b1;
          w_state_nxt = S_OPEN;
        end else if (btn_enter) begin
          w_set_wr = 1'b1;
        end
      end
      S_LOCKED: begin
        if (btn_enter && enb_inp) begin
          w_ent_wr      = 1'b1;
          w_enb_cnt_nxt = 1'b1;
          w_state_nxt   = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // An abort discards any digit presented in the same cycle.
        if (timer_reset) begin
          w_ent_clr   = 1'b1;
          w_err_nxt   = w_err_inc;
          w_state_nxt = w_fail_st;
        end else if (w_ent_full) begin
          w_state_nxt = S_CHECK;
        end else if (btn_enter && enb_inp) begin
          w_ent_wr = 1'b1;
        end
      end
      S_CHECK: begin
        w_dis_nxt = 1'b1;
        w_ent_clr = 1'b1;
        if (w_match) begin
          w_err_nxt   = '0;
          w_state_nxt = S_OPEN;
        end else begin
          w_err_nxt   = w_err_inc;
          w_state_nxt = w_fail_st;
        end
      end
      S_LOCKOUT: begin
        if (timer_reset) begin
          w_err_nxt   = '0;
          w_state_nxt = S_LOCKED;
        end
      end
      default: w_state_nxt = S_OPEN;
    endcase
  end

  // State, stored code and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state    <= S_OPEN;
      r_code     <= DEFAULT_CODE;
      r_err      <= '0;
      r_enb_lock <= 1'b0;
      r_enb_cnt  <= 1'b0;
      r_dis      <= 1'b0;
      r_ignore   <= 1'b0;
      r_gen_stop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (w_code_load) r_code <= w_set_data;
      r_err      <= w_err_nxt;
      r_enb_lock <= (w_state_nxt != S_OPEN) && (w_state_nxt != S_SET);
      r_enb_cnt  <= w_enb_cnt_nxt;
      r_dis      <= w_dis_nxt;
      r_ignore   <= (w_state_nxt == S_LOCKOUT) || ((w_state_nxt == S_ENTRY) && !enb_inp);
      r_gen_stop <= (w_state_nxt == S_LOCKOUT);
    end
  end

  assign enb_lock      = r_enb_lock;
  assign enb_cnt       = r_enb_cnt;
  assign disable_cnt   = r_dis;
  assign ignore        = r_ignore;
  assign gen_stop      = r_gen_stop;
  assign error_counter = r_err;
  // Only one buffer is ever non-empty, so the OR selects the active count.
  assign digit_idx     = w_ent_idx[2:0] | w_set_idx[2:0];
  assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_d_lock_ctrl.sv
// Self-checking bench for d_lock_ctrl with a transaction-level lock model.
module tb_d_lock_ctrl;
  import d_lock_pkg::*;

  localparam int MAXE = 3;
  localparam int M_OPEN = 0, M_LOCKED = 1, M_LOCKOUT = 2;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_digit = '0;
  logic       btn_enter = 1'b0, btn_set = 1'b0, btn_lock = 1'b0;
  logic       enb_set = 1'b0, enb_inp = 1'b1, timer_reset = 1'b0;
  logic       enb_lock, enb_cnt, disable_cnt, ignore, gen_stop;
  logic [2:0] error_counter, digit_idx;
  state_e     st;

  int total = 0;
  int bad = 0;

  // Reference model: stored code, failed-attempt count, coarse lock mode.
  logic [15:0] m_code = 16'h1234;
  int          m_err  = 0;
  int          m_mode = M_OPEN;

  d_lock_ctrl dut (
    .clk_in(clk_in), .rst_n(rst_n), .sw_digit(sw_digit), .btn_enter(btn_enter),
    .btn_set(btn_set), .btn_lock(btn_lock), .enb_set(enb_set), .enb_inp(enb_inp),
    .timer_reset(timer_reset), .enb_lock(enb_lock), .enb_cnt(enb_cnt),
    .disable_cnt(disable_cnt), .ignore(ignore), .gen_stop(gen_stop),
    .error_counter(error_counter), .digit_idx(digit_idx), .o_state_dbg(st)
  );

  // Clock and watchdog.
  always #4 clk_in = ~clk_in;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks: inputs change on the falling edge, outputs read there too.
  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic pulse_enter(input logic [3:0] d);
    sw_digit = d; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
  endtask

  task automatic pulse_lock();
    btn_lock = 1'b1; tick(); btn_lock = 1'b0;
  endtask

  task automatic pulse_set();
    btn_set = 1'b1; tick(); btn_set = 1'b0;
  endtask

  task automatic pulse_treset();
    timer_reset = 1'b1; tick(); timer_reset = 1'b0;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] c, input int i);
    return 4'(c >> (4 * (3 - i)));
  endfunction

  // One full keypad attempt from the locked state, checked against the model.
  task automatic run_attempt(input logic [15:0] ent, input string tag);
    logic exp_match, exp_out;
    exp_match = (ent == m_code);
    for (int i = 0; i < 4; i++) begin
      pulse_enter(nib(ent, i));
      if (i == 0) begin
        total++;
        if (enb_cnt !== 1'b1) begin bad++; $display("FAIL %s enb_cnt_pulse: got %b want 1", tag, enb_cnt); end
      end
      if (i == 1) begin
        total++;
        if (enb_cnt !== 1'b0) begin bad++; $display("FAIL %s enb_cnt_single: got %b want 0", tag, enb_cnt); end
      end
      if (i < 3) repeat ($urandom_range(0, 2)) tick();
    end
    total++;
    if (digit_idx !== 3'd4) begin bad++; $display("FAIL %s idx_full: got %0d want 4", tag, digit_idx); end
    tick();
    total++;
    if (disable_cnt !== 1'b0) begin bad++; $display("FAIL %s dis_early: got %b want 0", tag, disable_cnt); end
    tick();
    if (exp_match) begin
      m_err = 0; m_mode = M_OPEN;
    end else begin
      if (m_err < MAXE) m_err++;
      m_mode = (m_err == MAXE) ? M_LOCKOUT : M_LOCKED;
    end
    exp_out = (m_mode == M_LOCKOUT);
    total++;
    if (disable_cnt !== 1'b1) begin bad++; $display("FAIL %s dis_pulse: got %b want 1", tag, disable_cnt); end
    total++;
    if (error_counter !== 3'(m_err)) begin bad++; $display("FAIL %s err: got %0d want %0d", tag, error_counter, m_err); end
    total++;
    if (enb_lock !== !exp_match) begin bad++; $display("FAIL %s enb_lock: got %b want %b", tag, enb_lock, !exp_match); end
    total++;
    if ({gen_stop, ignore} !== {exp_out, exp_out}) begin
      bad++; $display("FAIL %s stop_ign: got %b%b want %b%b", tag, gen_stop, ignore, exp_out, exp_out);
    end
    total++;
    if (digit_idx !== 3'd0) begin bad++; $display("FAIL %s idx_clr: got %0d want 0", tag, digit_idx); end
    tick();
    total++;
    if (disable_cnt !== 1'b0) begin bad++; $display("FAIL %s dis_single: got %b want 0", tag, disable_cnt); end
  endtask

  // Program a new code from the open state.
  task automatic set_code(input logic [15:0] c, input string tag);
    enb_set = 1'b1;
    pulse_set();
    total++;
    if (st !== S_SET) begin bad++; $display("FAIL %s enter_set: got %0d want %0d", tag, st, S_SET); end
    for (int i = 0; i < 4; i++) pulse_enter(nib(c, i));
    tick();
    m_code = c;
    total++;
    if (st !== S_OPEN || digit_idx !== 3'd0 || enb_lock !== 1'b0) begin
      bad++; $display("FAIL %s commit: got st=%0d idx=%0d lock=%b want st=0 idx=0 lock=0", tag, st, digit_idx, enb_lock);
    end
    enb_set = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({enb_lock, enb_cnt, disable_cnt, ignore, gen_stop} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {enb_lock, enb_cnt, disable_cnt, ignore, gen_stop});
    end
    total++;
    if (error_counter !== 3'd0 || digit_idx !== 3'd0 || st !== S_OPEN) begin
      bad++; $display("FAIL reset_state: got err=%0d idx=%0d st=%0d want 0 0 0", error_counter, digit_idx, st);
    end
    rst_n = 1'b1;
    tick();
    m_code = 16'h1234; m_err = 0; m_mode = M_OPEN;
  endtask

  task automatic test_unlock();
    pulse_lock();
    m_mode = M_LOCKED;
    total++;
    if (enb_lock !== 1'b1 || st !== S_LOCKED) begin
      bad++; $display("FAIL lock_arm: got lock=%b st=%0d want 1 %0d", enb_lock, st, S_LOCKED);
    end
    run_attempt(16'h1234, "unlock_default");
  endtask

  task automatic test_lockout();
    pulse_lock();
    for (int a = 0; a < 3; a++) run_attempt(16'h1235, "wrong_code");
    pulse_enter(4'h1);
    total++;
    if (digit_idx !== 3'd0 || enb_cnt !== 1'b0 || gen_stop !== 1'b1) begin
      bad++; $display("FAIL lockout_ignore: got idx=%0d cnt=%b stop=%b want 0 0 1", digit_idx, enb_cnt, gen_stop);
    end
    pulse_lock();
    total++;
    if (st !== S_LOCKOUT) begin bad++; $display("FAIL lockout_hold: got %0d want %0d", st, S_LOCKOUT); end
  endtask

  task automatic test_timer_release();
    pulse_treset();
    m_err = 0; m_mode = M_LOCKED;
    total++;
    if (gen_stop !== 1'b0 || ignore !== 1'b0 || error_counter !== 3'd0 || st !== S_LOCKED) begin
      bad++; $display("FAIL release: got stop=%b ign=%b err=%0d st=%0d want 0 0 0 %0d",
                      gen_stop, ignore, error_counter, st, S_LOCKED);
    end
    run_attempt(16'h1234, "unlock_after_release");
  endtask

  task automatic test_set_code();
    set_code(16'h9876, "set_9876");
    pulse_lock();
    run_attempt(16'h1234, "old_code_rejected");
    run_attempt(16'h9876, "new_code_unlocks");
  endtask

  task automatic test_reset_mid();
    enb_set = 1'b1;
    pulse_set();
    pulse_enter(4'h1); pulse_enter(4'h2);
    enb_set = 1'b0;
    test_reset();
    pulse_lock();
    run_attempt(16'h9876, "lost_code_rejected");
    run_attempt(16'h1234, "default_restored");
  endtask

  task automatic test_set_abort();
    enb_set = 1'b1;
    pulse_set();
    pulse_enter(4'h5); pulse_enter(4'h5);
    total++;
    if (digit_idx !== 3'd2) begin bad++; $display("FAIL set_idx: got %0d want 2", digit_idx); end
    enb_set = 1'b0;
    tick();
    total++;
    if (st !== S_OPEN || digit_idx !== 3'd0) begin
      bad++; $display("FAIL set_abort: got st=%0d idx=%0d want 0 0", st, digit_idx);
    end
    pulse_lock();
    run_attempt(m_code, "code_unchanged");
  endtask

  task automatic test_abort();
    pulse_lock();
    pulse_enter(nib(m_code, 0)); pulse_enter(nib(m_code, 1));
    total++;
    if (digit_idx !== 3'd2) begin bad++; $display("FAIL abort_pre_idx: got %0d want 2", digit_idx); end
    sw_digit = 4'h3; btn_enter = 1'b1; timer_reset = 1'b1;
    tick();
    btn_enter = 1'b0; timer_reset = 1'b0;
    m_err = 1; m_mode = M_LOCKED;
    total++;
    if (error_counter !== 3'd1 || disable_cnt !== 1'b0 || digit_idx !== 3'd0 || st !== S_LOCKED) begin
      bad++; $display("FAIL abort: got err=%0d dis=%b idx=%0d st=%0d want 1 0 0 %0d",
                      error_counter, disable_cnt, digit_idx, st, S_LOCKED);
    end
    pulse_treset();
    total++;
    if (error_counter !== 3'd1 || st !== S_LOCKED) begin
      bad++; $display("FAIL treset_locked: got err=%0d st=%0d want 1 %0d", error_counter, st, S_LOCKED);
    end
    pulse_enter(nib(m_code, 0));
    enb_inp = 1'b0;
    tick();
    total++;
    if (ignore !== 1'b1) begin bad++; $display("FAIL ignore_on: got %b want 1", ignore); end
    pulse_enter(4'h9);
    total++;
    if (digit_idx !== 3'd1) begin bad++; $display("FAIL ignore_drop: got %0d want 1", digit_idx); end
    enb_inp = 1'b1;
    tick();
    total++;
    if (ignore !== 1'b0) begin bad++; $display("FAIL ignore_off: got %b want 0", ignore); end
    for (int i = 1; i < 4; i++) pulse_enter(nib(m_code, i));
    repeat (2) tick();
    m_err = 0; m_mode = M_OPEN;
    total++;
    if (disable_cnt !== 1'b1 || error_counter !== 3'd0 || enb_lock !== 1'b0) begin
      bad++; $display("FAIL ignore_unlock: got dis=%b err=%0d lock=%b want 1 0 0", disable_cnt, error_counter, enb_lock);
    end
  endtask

  task automatic test_random();
    logic [15:0] c, ent;
    for (int it = 0; it < 6; it++) begin
      c = 16'($urandom);
      set_code(c, "rand_set");
      pulse_lock();
      m_mode = M_LOCKED;
      for (int a = 0; a < 5; a++) begin
        if (m_mode == M_OPEN) begin pulse_lock(); m_mode = M_LOCKED; end
        if (m_mode == M_LOCKOUT) begin
          pulse_treset();
          m_err = 0; m_mode = M_LOCKED;
          total++;
          if (error_counter !== 3'd0 || gen_stop !== 1'b0) begin
            bad++; $display("FAIL rand_release: got err=%0d stop=%b want 0 0", error_counter, gen_stop);
          end
        end
        if ($urandom_range(0, 2) == 0) begin
          ent = m_code;
        end else begin
          ent = m_code ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        end
        run_attempt(ent, "rand_attempt");
      end
      if (m_mode == M_LOCKOUT) begin pulse_treset(); m_err = 0; m_mode = M_LOCKED; end
      if (m_mode == M_LOCKED) run_attempt(m_code, "rand_final");
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_timer_release();
    test_set_code();
    test_reset_mid();
    test_set_abort();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
